id_ex_stage: RTL and testbench

ID/EX pipeline stage of the RV32I core, directly upstream of the ALU. It registers decoded operands and control from the decode stage and resolves EX/MEM and MEM/WB forwarding. It then drives `operand1`, `operand2` and `alu_control` into the ALU. It implements stall (hold) and flush (bubble), and keeps forwarded values alive across stalls.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the RV32I core: op encoding and datapath sizes.
package alu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd8,
    ALU_SRA = 4'd9
  } alu_op_e;

  // Highest encoding the ALU implements; anything above is illegal.
  localparam logic [3:0] ALU_OP_MAX = 4'd9;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: selects the freshest value of one source register.
// x0 is never forwarded; EX/MEM wins over MEM/WB.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_addr,
  input  logic [XLEN-1:0] src_data,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  // Priority select: x0 guard, then EX/MEM, then MEM/WB, then register data.
  always_comb begin
    fwd_data = src_data;
    if (src_addr != '0) begin
      if (exm_reg_write && (exm_rd_addr == src_addr)) begin
        fwd_data = exm_result;
      end else if (wb_reg_write && (wb_rd_addr == src_addr)) begin
        fwd_data = wb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core. Captures decoded operands and
// control, resolves forwarding and drives the ALU operands. Stall holds the
// slot (refreshing operand data with forwarded values), flush inserts a bubble.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [3:0]      id_alu_control,
  input  logic            id_op1_pc,
  input  logic            id_op2_imm,
  input  logic            id_reg_write,
  input  logic            stall,
  input  logic            flush,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  import alu_pkg::*;

  logic            vld_p0;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] rs1_data_p0;
  logic [XLEN-1:0] rs2_data_p0;
  logic [XLEN-1:0] imm_p0;
  logic [RA_W-1:0] rs1_addr_p0;
  logic [RA_W-1:0] rs2_addr_p0;
  logic [RA_W-1:0] rd_addr_p0;
  logic [3:0]      alu_ctrl_p0;
  logic            op1_pc_p0;
  logic            op2_imm_p0;
  logic            reg_write_p0;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // ---- ID -> EX boundary: reset, flush bubble, stall hold with forward refresh, load
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0       <= 1'b0;
      pc_p0        <= '0;
      rs1_data_p0  <= '0;
      rs2_data_p0  <= '0;
      imm_p0       <= '0;
      rs1_addr_p0  <= '0;
      rs2_addr_p0  <= '0;
      rd_addr_p0   <= '0;
      alu_ctrl_p0  <= ALU_ADD;
      op1_pc_p0    <= 1'b0;
      op2_imm_p0   <= 1'b0;
      reg_write_p0 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
    end else if (stall) begin
      // Keep a value retiring from WB during the stall; it will be gone later.
      rs1_data_p0 <= fwd_rs1;
      rs2_data_p0 <= fwd_rs2;
    end else begin
      vld_p0       <= id_valid;
      pc_p0        <= id_pc;
      rs1_data_p0  <= id_rs1_data;
      rs2_data_p0  <= id_rs2_data;
      imm_p0       <= id_imm;
      rs1_addr_p0  <= id_rs1_addr;
      rs2_addr_p0  <= id_rs2_addr;
      rd_addr_p0   <= id_rd_addr;
      alu_ctrl_p0  <= id_alu_control;
      op1_pc_p0    <= id_op1_pc;
      op2_imm_p0   <= id_op2_imm;
      reg_write_p0 <= id_reg_write;
    end
  end

  // ---- EX: forwarding and operand selection (combinational to the ALU)
  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .src_addr      (rs1_addr_p0),
    .src_data      (rs1_data_p0),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .src_addr      (rs2_addr_p0),
    .src_data      (rs2_data_p0),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd_addr    (wb_rd_addr),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs2)
  );

  assign ex_valid      = vld_p0;
  assign operand1      = op1_pc_p0  ? pc_p0  : fwd_rs1;
  assign operand2      = op2_imm_p0 ? imm_p0 : fwd_rs2;
  assign alu_control   = alu_ctrl_p0;
  assign ex_store_data = fwd_rs2;
  assign ex_rd_addr    = rd_addr_p0;
  assign ex_reg_write  = vld_p0 & reg_write_p0;
  assign ex_illegal    = vld_p0 & (alu_ctrl_p0 > ALU_OP_MAX);

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a slot-level reference model.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]      id_alu_control;
  logic            id_op1_pc, id_op2_imm, id_reg_write;
  logic            stall, flush;
  logic            exm_reg_write;
  logic [RA_W-1:0] exm_rd_addr;
  logic [XLEN-1:0] exm_result;
  logic            wb_reg_write;
  logic [RA_W-1:0] wb_rd_addr;
  logic [XLEN-1:0] wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] operand1, operand2, ex_store_data;
  logic [3:0]      alu_control;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write, ex_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_control(id_alu_control), .id_op1_pc(id_op1_pc), .id_op2_imm(id_op2_imm),
    .id_reg_write(id_reg_write), .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .ex_valid(ex_valid), .operand1(operand1), .operand2(operand2),
    .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  // Reference model: the instruction currently occupying the EX slot.
  typedef struct {
    bit            valid;
    bit [XLEN-1:0] pc, rs1d, rs2d, imm;
    bit [RA_W-1:0] rs1a, rs2a, rda;
    bit [3:0]      op;
    bit            op1_pc, op2_imm, rw;
  } slot_t;

  slot_t m;

  function automatic bit [XLEN-1:0] ref_fwd(bit [RA_W-1:0] a, bit [XLEN-1:0] d);
    if (a == 0) return d;
    if (exm_reg_write && exm_rd_addr == a) return exm_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  function automatic void model_edge();
    slot_t n;
    n = m;
    if (rst) begin
      n = '{default: 0};
    end else if (flush) begin
      n.valid = 0;
    end else if (stall) begin
      n.rs1d = ref_fwd(m.rs1a, m.rs1d);
      n.rs2d = ref_fwd(m.rs2a, m.rs2d);
    end else begin
      n.valid = id_valid; n.pc = id_pc; n.rs1d = id_rs1_data; n.rs2d = id_rs2_data;
      n.imm = id_imm; n.rs1a = id_rs1_addr; n.rs2a = id_rs2_addr; n.rda = id_rd_addr;
      n.op = id_alu_control; n.op1_pc = id_op1_pc; n.op2_imm = id_op2_imm;
      n.rw = id_reg_write;
    end
    m = n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_alu_control = 0;
    id_op1_pc = 0; id_op2_imm = 0; id_reg_write = 0; stall = 0; flush = 0;
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    wb_reg_write = 0; wb_rd_addr = 0; wb_result = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; id_valid = 1; id_pc = 32'h100; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    id_imm = 32'h33; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 7;
    id_alu_control = 4'hC; id_reg_write = 1;
    tick(); tick();
    n_checks++;
    if ({ex_valid, operand1, operand2, alu_control, ex_store_data, ex_rd_addr,
         ex_reg_write, ex_illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b op1=%h op2=%h alu=%h st=%h rd=%0d rw=%0b ill=%0b, need all 0",
               ex_valid, operand1, operand2, alu_control, ex_store_data, ex_rd_addr,
               ex_reg_write, ex_illegal);
    end
    rst = 0;
    #3;
    n_checks++;
    if (ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_same_cycle: ex_valid=%0b need 0", ex_valid);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd_addr !== 5'd7 || operand1 !== 32'h11) begin
      n_fail++;
      $display("FAIL reset_first_capture: v=%0b rd=%0d op1=%h need 1/7/00000011",
               ex_valid, ex_rd_addr, operand1);
    end
  endtask

  task automatic test_basic_capture();
    idle_inputs();
    id_valid = 1; id_rs1_addr = 1; id_rs1_data = 5; id_imm = 7; id_op2_imm = 1;
    id_alu_control = 4'd0; id_rd_addr = 9; id_reg_write = 1;
    tick();
    n_checks++;
    if (operand1 !== 32'd5 || operand2 !== 32'd7 || alu_control !== 4'b0000 || ex_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_capture: op1=%0d op2=%0d alu=%b v=%0b need 5/7/0000/1",
               operand1, operand2, alu_control, ex_valid);
    end
    n_checks++;
    if (ex_reg_write !== 1'b1 || ex_rd_addr !== 5'd9 || ex_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ctrl: rw=%0b rd=%0d ill=%0b need 1/9/0", ex_reg_write, ex_rd_addr, ex_illegal);
    end
    // op1 from PC, op2 from rs2: store data always tracks rs2
    id_pc = 32'h4000; id_op1_pc = 1; id_op2_imm = 0; id_rs2_addr = 2; id_rs2_data = 32'hDEAD;
    tick();
    n_checks++;
    if (operand1 !== 32'h4000 || operand2 !== 32'hDEAD || ex_store_data !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL pc_select: op1=%h op2=%h st=%h need 00004000/0000dead/0000dead",
               operand1, operand2, ex_store_data);
    end
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 32'h1; id_rs2_addr = 3; id_rs2_data = 32'h2;
    tick();
    exm_reg_write = 1; exm_rd_addr = 3; exm_result = 32'hAAAA;
    wb_reg_write = 1; wb_rd_addr = 3; wb_result = 32'hBBBB;
    #1;
    n_checks++;
    if (operand1 !== 32'hAAAA || ex_store_data !== 32'hAAAA) begin
      n_fail++; $display("FAIL fwd_exm_priority: op1=%h st=%h need 0000aaaa", operand1, ex_store_data);
    end
    exm_reg_write = 0;
    #1;
    n_checks++;
    if (operand1 !== 32'hBBBB) begin
      n_fail++; $display("FAIL fwd_wb: op1=%h need 0000bbbb", operand1);
    end
    wb_rd_addr = 4;
    #1;
    n_checks++;
    if (operand1 !== 32'h1) begin
      n_fail++; $display("FAIL fwd_none: op1=%h need 00000001", operand1);
    end
  endtask

  task automatic test_x0_guard();
    idle_inputs();
    id_valid = 1; id_rs2_addr = 0; id_rs2_data = 0; id_op2_imm = 0;
    tick();
    exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'hFFFF;
    wb_reg_write = 1; wb_rd_addr = 0; wb_result = 32'hEEEE;
    #1;
    n_checks++;
    if (operand2 !== 32'h0 || ex_store_data !== 32'h0) begin
      n_fail++; $display("FAIL x0_guard: op2=%h st=%h need 0", operand2, ex_store_data);
    end
  endtask

  task automatic test_stall_retention();
    idle_inputs();
    id_valid = 1; id_rs1_addr = 4; id_rs1_data = 32'h55; id_rd_addr = 6; id_reg_write = 1;
    tick();
    // stalled cycle 1: WB retires x4
    stall = 1; wb_reg_write = 1; wb_rd_addr = 4; wb_result = 32'h1234;
    id_rs1_data = 32'h99; id_rd_addr = 8;
    #1;
    n_checks++;
    if (operand1 !== 32'h1234) begin
      n_fail++; $display("FAIL stall_cycle1: op1=%h need 00001234", operand1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      wb_reg_write = 0; wb_result = 32'h0;
      if (k == 2) stall = 0;
      #1;
      n_checks++;
      if (operand1 !== 32'h1234 || ex_rd_addr !== 5'd6 || ex_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: op1=%h rd=%0d v=%0b need 00001234/6/1",
                 k, operand1, ex_rd_addr, ex_valid);
      end
    end
    tick();
    n_checks++;
    if (operand1 !== 32'h99 || ex_rd_addr !== 5'd8) begin
      n_fail++; $display("FAIL stall_release: op1=%h rd=%0d need 00000099/8", operand1, ex_rd_addr);
    end
  endtask

  task automatic test_flush_illegal();
    idle_inputs();
    id_valid = 1; id_reg_write = 1; id_alu_control = 4'd1;
    tick();
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL flush_beats_stall: v=%0b rw=%0b need 0/0", ex_valid, ex_reg_write);
    end
    id_alu_control = 4'b1100;
    tick();
    n_checks++;
    if (ex_illegal !== 1'b1 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL illegal_op: ill=%0b v=%0b need 1/1", ex_illegal, ex_valid);
    end
    id_alu_control = 4'd9;
    tick();
    n_checks++;
    if (ex_illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_boundary9: ill=%0b need 0", ex_illegal);
    end
    id_alu_control = 4'd10;
    tick();
    n_checks++;
    if (ex_illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_boundary10: ill=%0b need 1", ex_illegal);
    end
    // bubble: illegal op but not valid must not flag
    id_valid = 0;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_illegal !== 1'b0 || ex_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL bubble_load: v=%0b ill=%0b rw=%0b need 0/0/0", ex_valid, ex_illegal, ex_reg_write);
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    id_valid = 1; id_alu_control = 4'd5; id_rd_addr = 3; id_reg_write = 1;
    tick();
    stall = 1;
    tick();
    rst = 1;
    tick();
    n_checks++;
    if (ex_valid !== 1'b0 || alu_control !== 4'd0 || ex_rd_addr !== 5'd0) begin
      n_fail++; $display("FAIL reset_mid_stall: v=%0b alu=%0d rd=%0d need 0/0/0", ex_valid, alu_control, ex_rd_addr);
    end
    rst = 0; stall = 0;
  endtask

  task automatic test_random();
    bit [XLEN-1:0] e1, e2, es;
    idle_inputs();
    rst = 1;
    model_edge();
    tick();
    rst = 0;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = RA_W'($urandom_range(0, 3)); id_rs2_addr = RA_W'($urandom_range(0, 3));
      id_rd_addr = RA_W'($urandom); id_alu_control = 4'($urandom);
      id_op1_pc = $urandom_range(0, 1); id_op2_imm = $urandom_range(0, 1);
      id_reg_write = $urandom_range(0, 1);
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 49) == 0);
      exm_reg_write = $urandom_range(0, 1); exm_rd_addr = RA_W'($urandom_range(0, 3));
      exm_result = $urandom;
      wb_reg_write = $urandom_range(0, 1); wb_rd_addr = RA_W'($urandom_range(0, 3));
      wb_result = $urandom;
      #1;
      e1 = m.op1_pc ? m.pc : ref_fwd(m.rs1a, m.rs1d);
      e2 = m.op2_imm ? m.imm : ref_fwd(m.rs2a, m.rs2d);
      es = ref_fwd(m.rs2a, m.rs2d);
      n_checks++;
      if (operand1 !== e1 || operand2 !== e2 || ex_store_data !== es) begin
        n_fail++;
        $display("FAIL rand_operands[%0d]: op1=%h op2=%h st=%h need %h/%h/%h",
                 i, operand1, operand2, ex_store_data, e1, e2, es);
      end
      n_checks++;
      if (ex_valid !== m.valid || alu_control !== m.op || ex_rd_addr !== m.rda ||
          ex_reg_write !== (m.valid & m.rw) || ex_illegal !== (m.valid && m.op > 4'd9)) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: v=%0b alu=%0d rd=%0d rw=%0b ill=%0b need %0b/%0d/%0d/%0b/%0b",
                 i, ex_valid, alu_control, ex_rd_addr, ex_reg_write, ex_illegal,
                 m.valid, m.op, m.rda, m.valid & m.rw, m.valid && m.op > 4'd9);
      end
      model_edge();
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_basic_capture();
    test_fwd_priority();
    test_x0_guard();
    test_stall_retention();
    test_flush_illegal();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
